// File: rtl/glitch_cmd_rx.sv
// UART (8N1) command receiver: bit-level deserializer feeding a framed
// command parser (A5, op, arg_h, arg_l, xor checksum) with an idle timeout.
module glitch_cmd_rx #(
  parameter int unsigned CLKS_PER_BIT = 434,
  parameter int unsigned TIMEOUT_CLKS = 50000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        uart_rx,
  output logic        cmd_valid,
  output logic [7:0]  cmd_op,
  output logic [15:0] cmd_arg,
  output logic        pll_relock,
  output logic        frame_err
);

  localparam logic [11:0] BIT_LAST  = 12'(CLKS_PER_BIT - 1);
  localparam logic [11:0] HALF_LAST = 12'(CLKS_PER_BIT / 2 - 1);
  localparam logic [19:0] TO_LAST   = 20'(TIMEOUT_CLKS - 1);
  localparam logic [7:0]  SYNC_BYTE = 8'hA5;

  typedef enum logic [1:0] {BIT_IDLE, BIT_START, BIT_DATA, BIT_STOP} bit_state_e;
  typedef enum logic [2:0] {P_SYNC, P_OP, P_ARG_H, P_ARG_L, P_CSUM} par_state_e;

  logic        sync1_q, sync2_q, rx_prev_q;
  bit_state_e  bit_state_q, bit_state_d;
  logic [11:0] bit_cnt_q, bit_cnt_d;
  logic [2:0]  bit_idx_q, bit_idx_d;
  logic [7:0]  shift_q, shift_d;
  logic        byte_done, stop_err;

  par_state_e  par_q, par_d;
  logic [19:0] to_cnt_q, to_cnt_d;
  logic        timeout;
  logic [7:0]  op_q, op_d, arg_h_q, arg_h_d, arg_l_q, arg_l_d;
  logic [7:0]  cmd_op_q, cmd_op_d;
  logic [15:0] cmd_arg_q, cmd_arg_d;
  logic        cmd_valid_q, cmd_valid_d, pll_relock_q, pll_relock_d;
  logic        frame_err_q, frame_err_d;

  always_comb begin
    bit_state_d = bit_state_q;
    bit_cnt_d   = bit_cnt_q;
    bit_idx_d   = bit_idx_q;
    shift_d     = shift_q;
    byte_done   = 1'b0;
    stop_err    = 1'b0;
    unique case (bit_state_q)
      BIT_IDLE: begin
        bit_cnt_d = '0;
        if (rx_prev_q && !sync2_q) bit_state_d = BIT_START;
      end
      BIT_START: begin
        if (bit_cnt_q == HALF_LAST) begin
          bit_cnt_d   = '0;
          bit_idx_d   = '0;
          bit_state_d = sync2_q ? BIT_IDLE : BIT_DATA;
        end else begin
          bit_cnt_d = bit_cnt_q + 12'd1;
        end
      end
      BIT_DATA: begin
        if (bit_cnt_q == BIT_LAST) begin
          bit_cnt_d = '0;
          shift_d   = {sync2_q, shift_q[7:1]};
          bit_idx_d = bit_idx_q + 3'd1;
          if (bit_idx_q == 3'd7) bit_state_d = BIT_STOP;
        end else begin
          bit_cnt_d = bit_cnt_q + 12'd1;
        end
      end
      BIT_STOP: begin
        if (bit_cnt_q == BIT_LAST) begin
          bit_cnt_d   = '0;
          bit_state_d = BIT_IDLE;
          if (sync2_q) byte_done = 1'b1;
          else         stop_err  = 1'b1;
        end else begin
          bit_cnt_d = bit_cnt_q + 12'd1;
        end
      end
      default: bit_state_d = BIT_IDLE;
    endcase
  end

  assign timeout = (par_q != P_SYNC) && (to_cnt_q == TO_LAST);

  always_comb begin
    par_d        = par_q;
    op_d         = op_q;
    arg_h_d      = arg_h_q;
    arg_l_d      = arg_l_q;
    cmd_op_d     = cmd_op_q;
    cmd_arg_d    = cmd_arg_q;
    cmd_valid_d  = 1'b0;
    pll_relock_d = 1'b0;
    frame_err_d  = 1'b0;

    if (par_q == P_SYNC || byte_done || timeout) to_cnt_d = '0;
    else                                         to_cnt_d = to_cnt_q + 20'd1;

    // byte_done outranks a coincident timeout; error causes collapse to one pulse
    if (byte_done) begin
      unique case (par_q)
        P_SYNC:  if (shift_q == SYNC_BYTE) par_d = P_OP;
        P_OP:    begin op_d    = shift_q; par_d = P_ARG_H; end
        P_ARG_H: begin arg_h_d = shift_q; par_d = P_ARG_L; end
        P_ARG_L: begin arg_l_d = shift_q; par_d = P_CSUM;  end
        P_CSUM: begin
          par_d = P_SYNC;
          if (shift_q == (op_q ^ arg_h_q ^ arg_l_q)) begin
            cmd_valid_d  = 1'b1;
            cmd_op_d     = op_q;
            cmd_arg_d    = {arg_h_q, arg_l_q};
            pll_relock_d = (op_q == 8'h01);
          end else begin
            frame_err_d = 1'b1;
          end
        end
        default: par_d = P_SYNC;
      endcase
    end else if (stop_err || timeout) begin
      frame_err_d = 1'b1;
      par_d       = P_SYNC;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q      <= 1'b1;
      sync2_q      <= 1'b1;
      rx_prev_q    <= 1'b1;
      bit_state_q  <= BIT_IDLE;
      bit_cnt_q    <= '0;
      bit_idx_q    <= '0;
      shift_q      <= '0;
      par_q        <= P_SYNC;
      to_cnt_q     <= '0;
      op_q         <= '0;
      arg_h_q      <= '0;
      arg_l_q      <= '0;
      cmd_op_q     <= '0;
      cmd_arg_q    <= '0;
      cmd_valid_q  <= 1'b0;
      pll_relock_q <= 1'b0;
      frame_err_q  <= 1'b0;
    end else begin
      sync1_q      <= uart_rx;
      sync2_q      <= sync1_q;
      rx_prev_q    <= sync2_q;
      bit_state_q  <= bit_state_d;
      bit_cnt_q    <= bit_cnt_d;
      bit_idx_q    <= bit_idx_d;
      shift_q      <= shift_d;
      par_q        <= par_d;
      to_cnt_q     <= to_cnt_d;
      op_q         <= op_d;
      arg_h_q      <= arg_h_d;
      arg_l_q      <= arg_l_d;
      cmd_op_q     <= cmd_op_d;
      cmd_arg_q    <= cmd_arg_d;
      cmd_valid_q  <= cmd_valid_d;
      pll_relock_q <= pll_relock_d;
      frame_err_q  <= frame_err_d;
    end
  end

  assign cmd_valid  = cmd_valid_q;
  assign cmd_op     = cmd_op_q;
  assign cmd_arg    = cmd_arg_q;
  assign pll_relock = pll_relock_q;
  assign frame_err  = frame_err_q;

endmodule

// File: tb/tb_glitch_cmd_rx.sv
// Directed bench for glitch_cmd_rx: a byte-level frame model predicts each
// output pulse and its cycle; a negedge process compares every cycle.
module tb_glitch_cmd_rx;
  localparam int CPB = 4;
  localparam int TO  = 200;
  // start-bit drive edge -> visible output pulse: 2 sync + 1 edge detect,
  // half a bit to mid-start, 9 bits to mid-stop
  localparam int LAT = 3 + CPB / 2 + 9 * CPB;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        uart_rx = 1'b1;
  logic        cmd_valid, pll_relock, frame_err;
  logic [7:0]  cmd_op;
  logic [15:0] cmd_arg;

  glitch_cmd_rx #(.CLKS_PER_BIT(CPB), .TIMEOUT_CLKS(TO)) dut (
    .clk(clk), .reset(reset), .uart_rx(uart_rx), .cmd_valid(cmd_valid),
    .cmd_op(cmd_op), .cmd_arg(cmd_arg), .pll_relock(pll_relock), .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          at;
    bit          is_valid;
    logic [7:0]  op;
    logic [15:0] arg;
  } ev_t;

  ev_t         evq[$];
  int          m_state = 0;  // 0 sync, 1 op, 2 arg_h, 3 arg_l, 4 csum
  logic [7:0]  m_op, m_ah, m_al;
  int          last_done = 0;
  logic [7:0]  hold_op = '0;
  logic [15:0] hold_arg = '0;

  int n_cmp = 0, n_bad = 0;
  int n_valid = 0, n_err = 0, n_pll = 0, last_err_cyc = -1;
  bit cmp_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s @cyc %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  task automatic push_ev(input int at, input bit v, input logic [7:0] op, input logic [15:0] arg);
    ev_t e;
    e.at = at; e.is_valid = v; e.op = op; e.arg = arg;
    evq.push_back(e);
  endtask

  // Timeout is certain if no byte can complete before the deadline.
  task automatic model_catch_up(input int earliest_done);
    if (m_state != 0 && earliest_done > last_done + TO) begin
      push_ev(last_done + TO, 1'b0, '0, '0);
      m_state = 0;
    end
  endtask

  task automatic model_byte(input int t0, input logic [7:0] b, input bit good);
    int d;
    d = t0 + LAT;
    model_catch_up(d);
    if (!good) begin
      push_ev(d, 1'b0, '0, '0);
      m_state = 0;
    end else begin
      last_done = d;
      case (m_state)
        0: if (b == 8'hA5) m_state = 1;
        1: begin m_op = b; m_state = 2; end
        2: begin m_ah = b; m_state = 3; end
        3: begin m_al = b; m_state = 4; end
        default: begin
          if (b == (m_op ^ m_ah ^ m_al)) push_ev(d, 1'b1, m_op, {m_ah, m_al});
          else                           push_ev(d, 1'b0, '0, '0);
          m_state = 0;
        end
      endcase
    end
  endtask

  task automatic model_reset;
    evq.delete();
    m_state  = 0;
    hold_op  = '0;
    hold_arg = '0;
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    model_catch_up(cyc + n + LAT);
    repeat (n) tick();
  endtask

  task automatic send_byte(input logic [7:0] b, input bit good, output int t0);
    tick();
    t0 = cyc;
    model_byte(t0, b, good);
    uart_rx = 1'b0;
    repeat (CPB) tick();
    for (int i = 0; i < 8; i++) begin
      uart_rx = b[i];
      repeat (CPB) tick();
    end
    uart_rx = good;
    repeat (CPB) tick();
    uart_rx = 1'b1;
    tick();
  endtask

  task automatic send_frame(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2,
                            input logic [7:0] b3, input logic [7:0] b4);
    int t;
    send_byte(b0, 1'b1, t);
    send_byte(b1, 1'b1, t);
    send_byte(b2, 1'b1, t);
    send_byte(b3, 1'b1, t);
    send_byte(b4, 1'b1, t);
  endtask

  always @(negedge clk) begin
    bit  ev_v, ev_e;
    ev_t e;
    if (cmp_en) begin
      ev_v = 1'b0;
      ev_e = 1'b0;
      while (evq.size() > 0 && evq[0].at < cyc) begin
        e = evq.pop_front();
        chk("missed_event", 32'(e.at), 32'(cyc));
      end
      if (evq.size() > 0 && evq[0].at == cyc) begin
        e = evq.pop_front();
        if (e.is_valid) begin
          ev_v = 1'b1; hold_op = e.op; hold_arg = e.arg;
        end else begin
          ev_e = 1'b1;
        end
      end
      chk("cmd_valid", 32'(cmd_valid), 32'(ev_v));
      chk("frame_err", 32'(frame_err), 32'(ev_e));
      chk("pll_relock", 32'(pll_relock), 32'(ev_v && hold_op == 8'h01));
      chk("cmd_op", 32'(cmd_op), 32'(hold_op));
      chk("cmd_arg", 32'(cmd_arg), 32'(hold_arg));
      if (cmd_valid)  n_valid++;
      if (frame_err) begin n_err++; last_err_cyc = cyc; end
      if (pll_relock) n_pll++;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish (compared %0d)", n_cmp);
    $fatal(1, "watchdog");
  end

  initial begin
    int v0, e0, p0, t, t02;
    @(posedge clk);
    cmp_en = 1'b1;
    repeat (2) tick();
    chk("reset_op", 32'(cmd_op), 32'h00);
    chk("reset_arg", 32'(cmd_arg), 32'h0000);
    chk("reset_pulses", 32'({cmd_valid, pll_relock, frame_err}), 32'h0);
    reset = 1'b0;
    idle(5);

    // relock command
    v0 = n_valid; e0 = n_err; p0 = n_pll;
    send_frame(8'hA5, 8'h01, 8'h12, 8'h34, 8'h27);
    idle(5);
    chk("s1_valid_cnt", 32'(n_valid - v0), 1);
    chk("s1_pll_cnt", 32'(n_pll - p0), 1);
    chk("s1_err_cnt", 32'(n_err - e0), 0);
    chk("s1_op", 32'(cmd_op), 32'h01);
    chk("s1_arg", 32'(cmd_arg), 32'h1234);

    // op 02, checksum 02^00^10 = 12
    v0 = n_valid; p0 = n_pll;
    send_frame(8'hA5, 8'h02, 8'h00, 8'h10, 8'h12);
    idle(5);
    chk("s2_valid_cnt", 32'(n_valid - v0), 1);
    chk("s2_pll_cnt", 32'(n_pll - p0), 0);
    chk("s2_op", 32'(cmd_op), 32'h02);
    chk("s2_arg", 32'(cmd_arg), 32'h0010);

    // bad checksums: outputs keep op 02 / arg 0010
    v0 = n_valid; e0 = n_err;
    send_frame(8'hA5, 8'h02, 8'h00, 8'h10, 8'h14);
    send_frame(8'hA5, 8'h02, 8'h00, 8'h10, 8'h13);
    idle(5);
    chk("s3_err_cnt", 32'(n_err - e0), 2);
    chk("s3_valid_cnt", 32'(n_valid - v0), 0);
    chk("s3_op", 32'(cmd_op), 32'h02);
    chk("s3_arg", 32'(cmd_arg), 32'h0010);

    // timeout mid-frame, then a good frame
    v0 = n_valid; e0 = n_err;
    send_byte(8'hA5, 1'b1, t);
    send_byte(8'h02, 1'b1, t02);
    idle(250);
    chk("s4_timeout_cyc", 32'(last_err_cyc), 32'(t02 + LAT + TO));
    send_frame(8'hA5, 8'h03, 8'hAB, 8'hCD, 8'h65);
    idle(5);
    chk("s4_err_cnt", 32'(n_err - e0), 1);
    chk("s4_valid_cnt", 32'(n_valid - v0), 1);
    chk("s4_op", 32'(cmd_op), 32'h03);
    chk("s4_arg", 32'(cmd_arg), 32'hABCD);

    // A5 with bad stop in SYNC, 1-cycle glitch, bad stop mid-frame
    v0 = n_valid; e0 = n_err;
    send_byte(8'hA5, 1'b0, t);
    idle(5);
    uart_rx = 1'b0;
    tick();
    uart_rx = 1'b1;
    idle(20);
    chk("s5_glitch_err", 32'(n_err - e0), 1);
    send_byte(8'hA5, 1'b1, t);
    send_byte(8'h02, 1'b0, t);
    idle(5);
    chk("s5_err_cnt", 32'(n_err - e0), 2);
    chk("s5_valid_cnt", 32'(n_valid - v0), 0);

    // A5 treated as data once synced
    send_frame(8'hA5, 8'hA5, 8'hA5, 8'hA5, 8'hA5);
    idle(5);
    chk("s6_op", 32'(cmd_op), 32'hA5);
    chk("s6_arg", 32'(cmd_arg), 32'hA5A5);

    // reset during ARG_H byte
    v0 = n_valid;
    send_byte(8'hA5, 1'b1, t);
    send_byte(8'h01, 1'b1, t);
    tick();
    uart_rx = 1'b0;
    repeat (CPB) tick();
    uart_rx = 1'b0; repeat (CPB) tick();
    uart_rx = 1'b1; repeat (CPB) tick();
    reset = 1'b1;
    @(posedge clk);
    model_reset();
    #1;
    chk("s7_rst_op", 32'(cmd_op), 32'h00);
    chk("s7_rst_arg", 32'(cmd_arg), 32'h0000);
    repeat (4) tick();
    reset = 1'b0;
    idle(5);
    send_frame(8'hA5, 8'h04, 8'h00, 8'h01, 8'h05);
    idle(300);
    chk("s7_valid_cnt", 32'(n_valid - v0), 1);
    chk("s7_op", 32'(cmd_op), 32'h04);
    chk("s7_arg", 32'(cmd_arg), 32'h0001);
    chk("queue_drained", 32'(evq.size()), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
